// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
//   mult_state_t : control FSM states
//   DEF_WIDTH    : default operand width, shared with the board top level
package mult_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

endpackage

// File: rtl/twos_mag.sv
// Splits a WIDTH-bit operand into an unsigned magnitude and a sign bit.
//   val       : operand
//   is_signed : 1 = treat val as two's-complement
//   mag       : |val| (the most-negative value maps to 2^(WIDTH-1))
//   sign      : 1 when val is negative in signed mode
module twos_mag #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] val,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = is_signed & val[WIDTH-1];
  // Negating the most-negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  assign mag  = sign ? (~val + 1'b1) : val;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, one partial product per clock.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (a, b, signed_mode)
//   out_valid/out_ready   : product handshake (product, 2*WIDTH bits)
//   busy                  : iteration in progress
// Operands are reduced to magnitudes on accept; the sign is reapplied to
// the final product, so the datapath itself is purely unsigned.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  mult_state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg;

  logic [WIDTH-1:0]   cap_mag_a, cap_mag_b;
  logic               cap_sign_a, cap_sign_b;

  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_nxt;
  logic [2*WIDTH-1:0] res;

  twos_mag #(.WIDTH(WIDTH)) u_mag_a (
    .val(a), .is_signed(signed_mode), .mag(cap_mag_a), .sign(cap_sign_a)
  );

  twos_mag #(.WIDTH(WIDTH)) u_mag_b (
    .val(b), .is_signed(signed_mode), .mag(cap_mag_b), .sign(cap_sign_b)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Upper half (with carry bit) plus the conditional addend, then shift the
  // whole accumulator right; after WIDTH steps the low 2*WIDTH bits hold
  // the magnitude product.
  assign sum     = acc[2*WIDTH:WIDTH] + {1'b0, (mag_b[0] ? mag_a : '0)};
  assign acc_nxt = {sum, acc[WIDTH-1:0]} >> 1;
  assign res     = acc_nxt[2*WIDTH-1:0];

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag_a <= cap_mag_a;
          mag_b <= cap_mag_b;
          neg   <= cap_sign_a ^ cap_sign_b;
          acc   <= '0;
          cnt   <= '0;
        end
        BUSY: begin
          acc   <= acc_nxt;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + 1'b1;
          if (last) product <= neg ? (~res + 1'b1) : res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks on a WIDTH=5 instance plus a randomised WIDTH=8
// regression against an integer reference product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid5 = 1'b0, out_ready5 = 1'b0, sm5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       in_ready5, out_valid5, busy5;
  logic [9:0] product5;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .signed_mode(sm5), .out_valid(out_valid5),
    .out_ready(out_ready5), .product(product5), .busy(busy5)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full WIDTH=5 transaction; hold = cycles out_ready stays low in DONE.
  task automatic run5(input string tag, input logic [4:0] ta, input logic [4:0] tb,
                      input logic tsm, input logic [9:0] exp, input int hold);
    int lat;
    bit to;
    to = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready5) begin to = 1'b0; break; end
    end
    chk({tag, "_rdy_to"}, 32'(to), 32'd0);
    in_valid5 = 1'b1; a5 = ta; b5 = tb; sm5 = tsm;
    @(posedge clk); #1;
    // Scramble inputs after accept; the result must not depend on them.
    in_valid5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom); sm5 = ~tsm;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk({tag, "_busy"}, 32'(busy5), 32'd1);
        chk({tag, "_inrdy_busy"}, 32'(in_ready5), 32'd0);
      end
      if (out_valid5) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_prod"}, 32'(product5), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(out_valid5), 32'd1);
      chk({tag, "_hold_prod"}, 32'(product5), 32'(exp));
      chk({tag, "_hold_inrdy"}, 32'(in_ready5), 32'd0);
    end
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready5 = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid5), 32'd0);
    chk({tag, "_inrdy_back"}, 32'(in_ready5), 32'd1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rsm;
    logic [15:0] e8;
    int          ia, ib, lat;
    bit          seen, to;

    #12;
    chk("rst_prod", 32'(product5), 32'd0);
    chk("rst_vld", 32'(out_valid5), 32'd0);
    chk("rst_busy", 32'(busy5), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_inrdy", 32'(in_ready5), 32'd1);

    run5("u31x31",  5'd31,   5'd31,   1'b0, 10'h3C1, 0);
    run5("s-16x-16", 5'b10000, 5'b10000, 1'b1, 10'h100, 0);
    run5("s-3x5",   5'h1D,   5'd5,    1'b1, 10'h3F1, 0);
    run5("u29x5",   5'h1D,   5'd5,    1'b0, 10'h091, 0);
    run5("s15x-16", 5'd15,   5'b10000, 1'b1, 10'h310, 0);
    run5("s-1x-1",  5'h1F,   5'h1F,   1'b1, 10'h001, 1);
    run5("u0x27",   5'd0,    5'd27,   1'b0, 10'h000, 3);
    run5("u7x9",    5'd7,    5'd9,    1'b0, 10'h03F, 0);

    // Reset during the third BUSY cycle: outputs clear at once, no result.
    @(negedge clk);
    in_valid5 = 1'b1; a5 = 5'd7; b5 = 5'd3; sm5 = 1'b0;
    @(posedge clk); #1; in_valid5 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_valid5), 32'd0);
    chk("midrst_busy", 32'(busy5), 32'd0);
    chk("midrst_prod", 32'(product5), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid5) seen = 1'b1;
    end
    chk("midrst_noout", 32'(seen), 32'd0);
    run5("u6x7", 5'd6, 5'd7, 1'b0, 10'h02A, 0);

    // WIDTH=8 random regression with input and output stalls.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rsm = 1'($urandom);
      ia = rsm ? int'($signed(ra)) : int'(ra);
      ib = rsm ? int'($signed(rb)) : int'(rb);
      e8 = 16'(ia * ib);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      to = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (in_ready8) begin to = 1'b0; break; end
      end
      if (to) chk("w8_rdy_to", 32'(to), 32'd0);
      in_valid8 = 1'b1; a8 = ra; b8 = rb; sm8 = rsm;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~rsm;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        lat++;
        if (out_valid8) break;
      end
      chk("w8_lat", 32'(lat), 32'd8);
      chk("w8_prod", 32'(product8), 32'(e8));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      chk("w8_stall_prod", 32'(product8), 32'(e8));
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
